// File: rtl/lcd_mem_arb_if.sv
// Memory-bus bundle between the Z80 path, the LCD fetch engine and the memory pins.
interface lcd_mem_arb_if;
  logic [21:0] cpu_ma;
  logic        cpu_mrq_n;
  logic        cpu_rd_n;
  logic        lcd_req;
  logic [21:0] lcd_addr;
  logic [7:0]  mem_di;
  logic [21:0] mem_a;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic [7:0]  lcd_data;
  logic        lcd_dv;
  logic        cpu_hold;
  logic        lcd_own;

  // Requesters and memory model side.
  modport master (
    output cpu_ma, cpu_mrq_n, cpu_rd_n, lcd_req, lcd_addr, mem_di,
    input  mem_a, mem_oe_n, mem_we_n, lcd_data, lcd_dv, cpu_hold, lcd_own
  );

  // Arbiter side.
  modport slave (
    input  cpu_ma, cpu_mrq_n, cpu_rd_n, lcd_req, lcd_addr, mem_di,
    output mem_a, mem_oe_n, mem_we_n, lcd_data, lcd_dv, cpu_hold, lcd_own
  );
endinterface

// File: rtl/lcd_mem_arb.sv
// Memory bus arbiter: the Z80 owns the bus by default, LCD screen fetches are slotted into
// MREQ-idle gaps, and a starving LCD request stalls the Z80 clock to force one fetch through.
module lcd_mem_arb #(
  parameter int unsigned RD_CYC     = 2,
  parameter int unsigned STARVE_MAX = 48,
  parameter int unsigned CNT_W      = 6
) (
  input logic          mck,
  input logic          rin,
  lcd_mem_arb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLcdRd, StHoldWait, StHoldRd} state_e;

  localparam logic [3:0]       PhaseLoad = 4'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);

  state_e           state_q, state_d;
  logic [3:0]       phase_q, phase_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [21:0]      lcd_addr_q, lcd_addr_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_dv_q, lcd_dv_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             lcd_own_q, lcd_own_d;

  // Next-state: arbitration FSM, read phase counter and starvation counter.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    starve_d   = starve_q;
    lcd_addr_d = lcd_addr_q;
    lcd_data_d = lcd_data_q;
    lcd_dv_d   = 1'b0;
    cpu_hold_d = cpu_hold_q;
    lcd_own_d  = lcd_own_q;

    unique case (state_q)
      StIdle: begin
        if (bus.lcd_req && (starve_q != StarveMax)) begin
          starve_d = starve_q + 1'b1;
        end
        // Gated by lcd_req so a cancelled forced fetch does not re-trigger the hold.
        if (bus.lcd_req && (starve_q == StarveMax)) begin
          state_d    = StHoldWait;
          cpu_hold_d = 1'b1;
        end else if (bus.lcd_req && bus.cpu_mrq_n) begin
          state_d    = StLcdRd;
          lcd_addr_d = bus.lcd_addr;
          lcd_own_d  = 1'b1;
          phase_d    = PhaseLoad;
        end
      end

      StLcdRd: begin
        if (!bus.cpu_mrq_n) begin
          // CPU wins; request stays pending and the counter keeps its value.
          state_d   = StIdle;
          lcd_own_d = 1'b0;
        end else if (phase_q == '0) begin
          lcd_data_d = bus.mem_di;
          lcd_dv_d   = bus.lcd_req;
          lcd_own_d  = 1'b0;
          starve_d   = '0;
          state_d    = StIdle;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      StHoldWait: begin
        if (!bus.lcd_req) begin
          state_d    = StIdle;
          cpu_hold_d = 1'b0;
        end else if (bus.cpu_mrq_n) begin
          state_d    = StHoldRd;
          lcd_addr_d = bus.lcd_addr;
          lcd_own_d  = 1'b1;
          phase_d    = PhaseLoad;
        end
      end

      StHoldRd: begin
        // Z80 clock is stopped here, so MREQ is not allowed to abort.
        if (phase_q == '0) begin
          lcd_data_d = bus.mem_di;
          lcd_dv_d   = bus.lcd_req;
          lcd_own_d  = 1'b0;
          cpu_hold_d = 1'b0;
          starve_d   = '0;
          state_d    = StIdle;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge mck) begin
    if (rin) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      starve_q   <= '0;
      lcd_addr_q <= '0;
      lcd_data_q <= 8'h00;
      lcd_dv_q   <= 1'b0;
      cpu_hold_q <= 1'b0;
      lcd_own_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      starve_q   <= starve_d;
      lcd_addr_q <= lcd_addr_d;
      lcd_data_q <= lcd_data_d;
      lcd_dv_q   <= lcd_dv_d;
      cpu_hold_q <= cpu_hold_d;
      lcd_own_q  <= lcd_own_d;
    end
  end

  // Bus mux: CPU strobes pass straight through unless the LCD owns the bus.
  always_comb begin
    if (lcd_own_q) begin
      bus.mem_a    = lcd_addr_q;
      bus.mem_oe_n = 1'b0;
      bus.mem_we_n = 1'b1;
    end else begin
      bus.mem_a    = bus.cpu_ma;
      bus.mem_oe_n = bus.cpu_mrq_n | bus.cpu_rd_n;
      bus.mem_we_n = bus.cpu_mrq_n | ~bus.cpu_rd_n;
    end
  end

  assign bus.lcd_data = lcd_data_q;
  assign bus.lcd_dv   = lcd_dv_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.lcd_own  = lcd_own_q;

endmodule

// File: tb/tb_lcd_mem_arb.sv
// Bench for lcd_mem_arb: scenario tasks with inline checks plus a scoreboard of expected
// fetched bytes that is drained whenever lcd_dv pulses.
module tb_lcd_mem_arb;
  logic mck = 1'b0;
  logic rin = 1'b1;
  always #5 mck = ~mck;

  lcd_mem_arb_if bus ();

  lcd_mem_arb #(
    .RD_CYC    (2),
    .STARVE_MAX(48),
    .CNT_W     (6)
  ) dut (
    .mck(mck),
    .rin(rin),
    .bus(bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;

  task automatic step();
    @(posedge mck);
    #1;
  endtask

  // Scoreboard: every lcd_dv must match the oldest expected byte.
  initial begin
    forever begin
      @(negedge mck);
      if (bus.lcd_dv === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_dv: lcd_data=%h but no fetch expected", bus.lcd_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if (bus.lcd_data !== sb_exp) begin
            n_err++;
            $display("FAIL sb_data: got %h want %h", bus.lcd_data, sb_exp);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rin = 1'b1;
    bus.cpu_ma = 22'h15_5555; bus.cpu_mrq_n = 1'b1; bus.cpu_rd_n = 1'b0;
    step(); step();
    n_cmp++;
    if ({bus.lcd_own, bus.cpu_hold, bus.lcd_dv, bus.lcd_data} !== 11'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got own/hold/dv/data=%b%b%b/%h want 000/00",
               bus.lcd_own, bus.cpu_hold, bus.lcd_dv, bus.lcd_data);
    end
    n_cmp++;
    if ({bus.mem_a, bus.mem_oe_n, bus.mem_we_n} !== {22'h15_5555, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL reset_bus: got a=%h oe=%b we=%b want 155555 1 1",
               bus.mem_a, bus.mem_oe_n, bus.mem_we_n);
    end
    n_cmp++;
    if (dut.starve_q !== 6'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d want 0", dut.starve_q);
    end
    rin = 1'b0;
  endtask

  task automatic test_lcd_fetch();
    bus.lcd_addr = 22'h04_0100; bus.mem_di = 8'h5A; bus.lcd_req = 1'b1;
    exp_q.push_back(8'hA5);
    step();  // acceptance edge
    n_cmp++;
    if ({bus.lcd_own, bus.mem_oe_n, bus.mem_we_n, bus.mem_a} !== {3'b101, 22'h04_0100}) begin
      n_err++;
      $display("FAIL fetch_cyc1: got own=%b oe=%b we=%b a=%h want 1 0 1 040100",
               bus.lcd_own, bus.mem_oe_n, bus.mem_we_n, bus.mem_a);
    end
    bus.mem_di = 8'hA5;  // only the last read cycle is sampled
    step();
    n_cmp++;
    if ({bus.lcd_own, bus.mem_oe_n, bus.lcd_dv, bus.mem_a} !== {3'b100, 22'h04_0100}) begin
      n_err++;
      $display("FAIL fetch_cyc2: got own=%b oe=%b dv=%b a=%h want 1 0 0 040100",
               bus.lcd_own, bus.mem_oe_n, bus.lcd_dv, bus.mem_a);
    end
    step();
    n_cmp++;
    if ({bus.lcd_dv, bus.lcd_own, bus.lcd_data} !== {2'b10, 8'hA5}) begin
      n_err++;
      $display("FAIL fetch_dv: got dv=%b own=%b data=%h want 1 0 a5",
               bus.lcd_dv, bus.lcd_own, bus.lcd_data);
    end
    bus.lcd_req = 1'b0;
    step();
    n_cmp++;
    if ({bus.lcd_dv, bus.lcd_own} !== 2'b00) begin
      n_err++; $display("FAIL fetch_single_pulse: got dv=%b own=%b want 0 0",
                        bus.lcd_dv, bus.lcd_own);
    end
  endtask

  task automatic test_cpu_passthrough();
    bus.cpu_ma = 22'h08_1234; bus.cpu_mrq_n = 1'b0; bus.cpu_rd_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_a, bus.mem_oe_n, bus.mem_we_n, bus.lcd_own} !== {22'h08_1234, 3'b010}) begin
      n_err++;
      $display("FAIL cpu_read: got a=%h oe=%b we=%b own=%b want 081234 0 1 0",
               bus.mem_a, bus.mem_oe_n, bus.mem_we_n, bus.lcd_own);
    end
    bus.cpu_rd_n = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_oe_n, bus.mem_we_n} !== 2'b10) begin
      n_err++; $display("FAIL cpu_write: got oe=%b we=%b want 1 0", bus.mem_oe_n, bus.mem_we_n);
    end
    bus.cpu_mrq_n = 1'b1; bus.cpu_rd_n = 1'b0;
    step();
  endtask

  task automatic test_abort();
    bus.lcd_addr = 22'h0A_5A5A; bus.mem_di = 8'h3C; bus.lcd_req = 1'b1;
    exp_q.push_back(8'h3C);  // only the retry delivers data
    step();  // accepted
    step();  // second LCD_RD cycle
    bus.cpu_mrq_n = 1'b0; bus.cpu_ma = 22'h01_2345;
    #1;
    n_cmp++;
    if ({bus.lcd_own, bus.mem_a} !== {1'b1, 22'h0A_5A5A}) begin
      n_err++; $display("FAIL abort_before: got own=%b a=%h want 1 0a5a5a", bus.lcd_own, bus.mem_a);
    end
    step();
    n_cmp++;
    if ({bus.lcd_own, bus.lcd_dv, bus.mem_a} !== {2'b00, 22'h01_2345}) begin
      n_err++;
      $display("FAIL abort_after: got own=%b dv=%b a=%h want 0 0 012345",
               bus.lcd_own, bus.lcd_dv, bus.mem_a);
    end
    step(); step();
    n_cmp++;
    if (dut.starve_q !== 6'd3) begin
      n_err++; $display("FAIL abort_cnt_accum: got %0d want 3", dut.starve_q);
    end
    bus.cpu_mrq_n = 1'b1;
    step();
    n_cmp++;
    if ({bus.lcd_own, bus.mem_a} !== {1'b1, 22'h0A_5A5A}) begin
      n_err++; $display("FAIL retry_own: got own=%b a=%h want 1 0a5a5a", bus.lcd_own, bus.mem_a);
    end
    step(); step();
    n_cmp++;
    if ({bus.lcd_dv, bus.lcd_data, dut.starve_q} !== {1'b1, 8'h3C, 6'd0}) begin
      n_err++; $display("FAIL retry_dv: got dv=%b data=%h cnt=%0d want 1 3c 0",
                        bus.lcd_dv, bus.lcd_data, dut.starve_q);
    end
    bus.lcd_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    bus.lcd_addr = 22'h1F_0F0F; bus.mem_di = 8'hC3; bus.cpu_ma = 22'h02_0000;
    bus.cpu_mrq_n = 1'b0; bus.cpu_rd_n = 1'b0; bus.lcd_req = 1'b1;
    exp_q.push_back(8'hC3);
    for (int i = 0; i < 48; i++) step();
    n_cmp++;
    if ({bus.cpu_hold, dut.starve_q} !== {1'b0, 6'd48}) begin
      n_err++; $display("FAIL starve_48: got hold=%b cnt=%0d want 0 48", bus.cpu_hold, dut.starve_q);
    end
    step();
    n_cmp++;
    if ({bus.cpu_hold, bus.lcd_own, bus.mem_a} !== {2'b10, 22'h02_0000}) begin
      n_err++; $display("FAIL starve_hold: got hold=%b own=%b a=%h want 1 0 020000",
                        bus.cpu_hold, bus.lcd_own, bus.mem_a);
    end
    step();
    n_cmp++;
    if ({bus.cpu_hold, bus.lcd_own} !== 2'b10) begin
      n_err++; $display("FAIL hold_wait: got hold=%b own=%b want 1 0", bus.cpu_hold, bus.lcd_own);
    end
    bus.cpu_mrq_n = 1'b1;
    step();
    n_cmp++;
    if ({bus.cpu_hold, bus.lcd_own, bus.mem_oe_n, bus.mem_a} !== {3'b110, 22'h1F_0F0F}) begin
      n_err++; $display("FAIL hold_rd: got hold=%b own=%b oe=%b a=%h want 1 1 0 1f0f0f",
                        bus.cpu_hold, bus.lcd_own, bus.mem_oe_n, bus.mem_a);
    end
    bus.cpu_mrq_n = 1'b0;  // must not abort the forced fetch
    step();
    n_cmp++;
    if ({bus.cpu_hold, bus.lcd_own, bus.mem_a} !== {2'b11, 22'h1F_0F0F}) begin
      n_err++; $display("FAIL hold_no_abort: got hold=%b own=%b a=%h want 1 1 1f0f0f",
                        bus.cpu_hold, bus.lcd_own, bus.mem_a);
    end
    step();
    n_cmp++;
    if ({bus.lcd_dv, bus.cpu_hold, bus.lcd_own, bus.lcd_data, dut.starve_q}
        !== {3'b100, 8'hC3, 6'd0}) begin
      n_err++; $display("FAIL hold_done: got dv=%b hold=%b own=%b data=%h cnt=%0d want 1 0 0 c3 0",
                        bus.lcd_dv, bus.cpu_hold, bus.lcd_own, bus.lcd_data, dut.starve_q);
    end
    bus.lcd_req = 1'b0; bus.cpu_mrq_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [21:0] a;
    logic [7:0]  d;
    for (int k = 0; k < 3; k++) begin
      a = 22'($urandom);
      d = 8'h80 | 8'($urandom);
      bus.lcd_addr = a; bus.mem_di = d; bus.lcd_req = 1'b1;
      exp_q.push_back(d);
      step();
      n_cmp++;
      if ({bus.lcd_own, bus.mem_a} !== {1'b1, a}) begin
        n_err++; $display("FAIL b2b_own[%0d]: got own=%b a=%h want 1 %h", k, bus.lcd_own,
                          bus.mem_a, a);
      end
      step(); step();
      n_cmp++;
      if ({bus.lcd_dv, bus.lcd_data} !== {1'b1, d}) begin
        n_err++; $display("FAIL b2b_dv[%0d]: got dv=%b data=%h want 1 %h", k, bus.lcd_dv,
                          bus.lcd_data, d);
      end
    end
    bus.lcd_req = 1'b0;
    step();
    n_cmp++;
    if ({bus.lcd_dv, bus.lcd_own} !== 2'b00) begin
      n_err++; $display("FAIL b2b_end: got dv=%b own=%b want 0 0", bus.lcd_dv, bus.lcd_own);
    end
  endtask

  task automatic test_cancel();
    bus.lcd_addr = 22'h00_0042; bus.mem_di = 8'h99; bus.lcd_req = 1'b1;
    step();
    bus.lcd_req = 1'b0;  // cancelled: read finishes silently
    step(); step();
    n_cmp++;
    if ({bus.lcd_own, bus.lcd_dv} !== 2'b00) begin
      n_err++; $display("FAIL cancel_rd: got own=%b dv=%b want 0 0", bus.lcd_own, bus.lcd_dv);
    end
    step();
  endtask

  task automatic test_same_edge_and_resets();
    bus.lcd_req = 1'b1; bus.cpu_mrq_n = 1'b0; bus.lcd_addr = 22'h2A_AAAA;
    step();
    n_cmp++;
    if ({bus.lcd_own, dut.starve_q} !== {1'b0, 6'd1}) begin
      n_err++; $display("FAIL same_edge: got own=%b cnt=%0d want 0 1", bus.lcd_own, dut.starve_q);
    end
    bus.cpu_mrq_n = 1'b1;
    step();  // now in LCD_RD
    rin = 1'b1;
    step();
    n_cmp++;
    if ({bus.lcd_own, bus.cpu_hold, bus.lcd_dv, bus.lcd_data, dut.starve_q} !== 17'h0) begin
      n_err++; $display("FAIL rst_mid_rd: got own=%b hold=%b dv=%b data=%h cnt=%0d want all 0",
                        bus.lcd_own, bus.cpu_hold, bus.lcd_dv, bus.lcd_data, dut.starve_q);
    end
    rin = 1'b0; bus.cpu_mrq_n = 1'b0;
    for (int i = 0; i < 49; i++) step();
    n_cmp++;
    if (bus.cpu_hold !== 1'b1) begin
      n_err++; $display("FAIL hold_again: got hold=%b want 1", bus.cpu_hold);
    end
    bus.lcd_req = 1'b0;
    step();
    n_cmp++;
    if ({bus.cpu_hold, bus.lcd_own} !== 2'b00) begin
      n_err++; $display("FAIL hold_cancel: got hold=%b own=%b want 0 0", bus.cpu_hold, bus.lcd_own);
    end
    bus.lcd_req = 1'b1;
    step();
    rin = 1'b1;
    step();
    n_cmp++;
    if ({bus.lcd_own, bus.cpu_hold, bus.lcd_dv, bus.lcd_data, dut.starve_q} !== 17'h0) begin
      n_err++; $display("FAIL rst_mid_hold: got own=%b hold=%b dv=%b data=%h cnt=%0d want all 0",
                        bus.lcd_own, bus.cpu_hold, bus.lcd_dv, bus.lcd_data, dut.starve_q);
    end
    rin = 1'b0; bus.lcd_req = 1'b0; bus.cpu_mrq_n = 1'b1;
    step();
    n_cmp++;
    if (bus.cpu_hold !== 1'b0) begin
      n_err++; $display("FAIL post_rst_hold: got %b want 0", bus.cpu_hold);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cpu_ma = '0; bus.cpu_mrq_n = 1'b1; bus.cpu_rd_n = 1'b1;
    bus.lcd_req = 1'b0; bus.lcd_addr = '0; bus.mem_di = '0;
    test_reset();
    test_lcd_fetch();
    test_cpu_passthrough();
    test_abort();
    test_starvation();
    test_back_to_back();
    test_cancel();
    test_same_edge_and_resets();
    step(); step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_leftover: got %0d outstanding want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
